// File: rtl/move_seq_pkg.sv
// Shared encodings for the 24-game move sequencer: FSM states, numberpad key codes, ALU ops.
package move_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_SEL_A, S_SEL_OP, S_SEL_B, S_EXEC, S_DONE
  } state_t;

  typedef enum logic [3:0] {
    KEY_SLOT0  = 4'd0,
    KEY_SLOT1  = 4'd1,
    KEY_SLOT2  = 4'd2,
    KEY_SLOT3  = 4'd3,
    KEY_ADD    = 4'd4,
    KEY_SUB    = 4'd5,
    KEY_MUL    = 4'd6,
    KEY_DIV    = 4'd7,
    KEY_CANCEL = 4'd8,
    KEY_UNDO   = 4'd9
  } key_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3
  } alu_op_t;

  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    case (k)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/slot_compactor.sv
// Combinational write-back: result lands in the lower selected slot, the upper one is
// removed and everything above it shifts down, leaving the old top live slot zeroed.
module slot_compactor #(
  parameter int W = 8
) (
  input  logic [3:0][W-1:0] slots,
  input  logic [1:0]        how_many,
  input  logic [1:0]        a,
  input  logic [1:0]        b,
  input  logic [W-1:0]      result,
  output logic [3:0][W-1:0] next_slots
);

  logic [1:0]        lo;
  logic [1:0]        hi;
  logic [4:0][W-1:0] ext;

  always_comb begin
    lo         = (a < b) ? a : b;
    hi         = (a < b) ? b : a;
    ext        = {{W{1'b0}}, slots};
    next_slots = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == int'(lo))
        next_slots[i] = result;
      else if (i < int'(hi))
        next_slots[i] = slots[i];
      else if (i < int'(how_many))
        next_slots[i] = ext[i+1];
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// One-move sequencer for the 24 game: slot A, operator, slot B, ALU req/ack, write-back.
// Optional one-deep undo snapshot enabled by defining MOVE_SEQUENCER_UNDO_EN.
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter int W      = 8,
  parameter int TARGET = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  set_num,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic         alu_req,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic         alu_ack,
  input  logic [W-1:0] alu_result,
  input  logic         alu_err,
  output logic [W-1:0] num1,
  output logic [W-1:0] num2,
  output logic [W-1:0] num3,
  output logic [W-1:0] num4,
  output logic [1:0]   how_many,
  output logic         win,
  output logic         lose,
  output logic         move_err
);

  localparam logic [W-1:0] TGT = W'(TARGET);

  state_t            state, state_d;
  logic [3:0][W-1:0] num, num_d, comp;
  logic [1:0]        hm_d, sel_a, sel_a_d, sel_b, sel_b_d, op_q, op_d, aop_d;
  logic              req_d, win_d, lose_d, merr_d;
  logic [W-1:0]      a_d, b_d;
  logic              load, slot_key, op_key, cancel, undo_hit;
  logic [3:0][W-1:0] snap_num;
  logic [1:0]        snap_hm;

  assign load     = start && (state != S_EXEC);
  assign slot_key = key_valid && (key_code < 4'd4) && (key_code[1:0] <= how_many);
  assign op_key   = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
  assign cancel   = key_valid && (key_code == KEY_CANCEL);

`ifdef MOVE_SEQUENCER_UNDO_EN
  logic snap_vld, commit;

  assign commit   = (state == S_EXEC) && alu_req && alu_ack && !alu_err;
  assign undo_hit = key_valid && (key_code == KEY_UNDO) && snap_vld &&
                    ((state == S_SEL_A) || (state == S_DONE));

  // Snapshot holds the slots as they were before the last committed move.
  always_ff @(posedge clk) begin
    if (rst || load || undo_hit) begin
      snap_vld <= 1'b0;
    end else if (commit) begin
      snap_vld <= 1'b1;
      snap_num <= num;
      snap_hm  <= how_many;
    end
  end
`else
  assign undo_hit = 1'b0;
  assign snap_num = num;
  assign snap_hm  = how_many;
`endif

  slot_compactor #(.W(W)) u_comp (
    .slots      (num),
    .how_many   (how_many),
    .a          (sel_a),
    .b          (sel_b),
    .result     (alu_result),
    .next_slots (comp)
  );

  always_comb begin
    state_d = state;
    num_d   = num;
    hm_d    = how_many;
    sel_a_d = sel_a;
    sel_b_d = sel_b;
    op_d    = op_q;
    req_d   = alu_req;
    a_d     = alu_a;
    b_d     = alu_b;
    aop_d   = alu_op;
    merr_d  = 1'b0;
    if (load) begin
      for (int i = 0; i < 4; i++) num_d[i] = W'(set_num[4*i +: 4]);
      hm_d    = 2'd3;
      state_d = S_SEL_A;
    end else begin
      unique case (state)
        S_SEL_A: begin
          if (slot_key) begin
            sel_a_d = key_code[1:0];
            state_d = S_SEL_OP;
          end else if (undo_hit) begin
            num_d = snap_num;
            hm_d  = snap_hm;
          end
        end
        S_SEL_OP: begin
          if (op_key) begin
            op_d    = key_to_op(key_code);
            state_d = S_SEL_B;
          end else if (cancel) begin
            state_d = S_SEL_A;
          end
        end
        S_SEL_B: begin
          if (slot_key && (key_code[1:0] != sel_a)) begin
            sel_b_d = key_code[1:0];
            state_d = S_EXEC;
          end else if (cancel) begin
            state_d = S_SEL_A;
          end
        end
        S_EXEC: begin
          // First EXEC cycle captures operands; they stay frozen until the ack.
          if (!alu_req) begin
            req_d = 1'b1;
            a_d   = num[sel_a];
            b_d   = num[sel_b];
            aop_d = op_q;
          end else if (alu_ack) begin
            req_d = 1'b0;
            if (alu_err) begin
              merr_d  = 1'b1;
              state_d = S_SEL_A;
            end else begin
              num_d   = comp;
              hm_d    = how_many - 2'd1;
              state_d = (how_many == 2'd1) ? S_DONE : S_SEL_A;
            end
          end
        end
        S_DONE: begin
          if (undo_hit) begin
            num_d   = snap_num;
            hm_d    = snap_hm;
            state_d = S_SEL_A;
          end
        end
        default: ;
      endcase
    end
    win_d  = (state_d == S_DONE) && (num_d[0] == TGT);
    lose_d = (state_d == S_DONE) && (num_d[0] != TGT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      num      <= '0;
      how_many <= 2'd3;
      sel_a    <= '0;
      sel_b    <= '0;
      op_q     <= '0;
      alu_req  <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      win      <= 1'b0;
      lose     <= 1'b0;
      move_err <= 1'b0;
    end else begin
      state    <= state_d;
      num      <= num_d;
      how_many <= hm_d;
      sel_a    <= sel_a_d;
      sel_b    <= sel_b_d;
      op_q     <= op_d;
      alu_req  <= req_d;
      alu_a    <= a_d;
      alu_b    <= b_d;
      alu_op   <= aop_d;
      win      <= win_d;
      lose     <= lose_d;
      move_err <= merr_d;
    end
  end

  assign num1 = num[0];
  assign num2 = num[1];
  assign num3 = num[2];
  assign num4 = num[3];

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: list-based game model, bench-side ALU, request scoreboard.
module tb_move_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, key_valid, alu_ack, alu_err;
  logic [15:0]  set_num;
  logic [3:0]   key_code;
  logic [W-1:0] alu_result;
  logic         alu_req, win, lose, move_err;
  logic [W-1:0] alu_a, alu_b, num1, num2, num3, num4;
  logic [1:0]   alu_op, how_many;

  move_sequencer #(.W(W), .TARGET(24)) dut (
    .clk(clk), .rst(rst), .start(start), .set_num(set_num),
    .key_valid(key_valid), .key_code(key_code),
    .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_ack(alu_ack), .alu_result(alu_result), .alu_err(alu_err),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .how_many(how_many), .win(win), .lose(lose), .move_err(move_err)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int b; int op; } req_t;

  int   total = 0;
  int   bad   = 0;
  int   model[$];
  req_t req_q[$];
  req_t cur;
  bit   req_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Request monitor: every new alu_req must match the oldest predicted operation,
  // and the operands must stay put while the request is held.
  always @(negedge clk) begin
    if (alu_req && !req_seen) begin
      req_seen = 1;
      if (req_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_req: got a=%0d b=%0d op=%0d expected none", alu_a, alu_b, alu_op);
        cur = '{a: -1, b: -1, op: -1};
      end else begin
        cur = req_q.pop_front();
        chk("req_a", alu_a, cur.a);
        chk("req_b", alu_b, cur.b);
        chk("req_op", alu_op, cur.op);
      end
    end else if (alu_req && cur.a >= 0) begin
      chk("hold_a", alu_a, cur.a);
      chk("hold_b", alu_b, cur.b);
      chk("hold_op", alu_op, cur.op);
    end
    if (!alu_req) req_seen = 0;
  end

  function automatic int get_num(input int i);
    case (i)
      0: return int'(num1);
      1: return int'(num2);
      2: return int'(num3);
      default: return int'(num4);
    endcase
  endfunction

  task automatic check_state(input string tag, input int err_exp);
    bit done;
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_num%0d", tag, i + 1), get_num(i), (i < model.size()) ? model[i] : 0);
    chk({tag, "_how_many"}, how_many, model.size() - 1);
    done = (model.size() == 1);
    chk({tag, "_win"}, win, (done && model[0] == 24) ? 1 : 0);
    chk({tag, "_lose"}, lose, (done && model[0] != 24) ? 1 : 0);
    chk({tag, "_move_err"}, move_err, err_exp);
  endtask

  task automatic key(input int k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic load(input int n0, input int n1, input int n2, input int n3, input bit with_key);
    @(negedge clk);
    start   = 1'b1;
    set_num = {4'(n3), 4'(n2), 4'(n1), 4'(n0)};
    if (with_key) begin
      key_valid = 1'b1;
      key_code  = 4'd1;
    end
    @(negedge clk);
    start     = 1'b0;
    key_valid = 1'b0;
    model     = '{n0, n1, n2, n3};
    check_state("load", 0);
  endtask

  // Reference arithmetic: any result outside 0..255 or an inexact/zero division is an error.
  task automatic alu_model(input int a, input int b, input int op, output int r, output bit e);
    e = 0;
    r = 0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      default: begin
        if (b == 0 || (a % b) != 0) e = 1;
        else r = a / b;
      end
    endcase
    if (r < 0 || r > 255) e = 1;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!alu_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = alu_req;
    if (!ok) begin
      total++; bad++;
      $display("FAIL req_timeout: got alu_req=0 expected 1");
    end
  endtask

  task automatic move(input int a, input int op, input int b, input bit junk, input bit start_in_exec);
    int  sz = model.size();
    int  r, lo, hi;
    bit  e, ok;
    if (junk) key((sz < 4) ? $urandom_range(sz, 3) : $urandom_range(4, 8));
    key(a);
    if (junk) begin
      key(8);
      key(a);
    end
    key(4 + op);
    if (junk) begin
      key(a);
      key(4);
      if (sz < 4) key(3);
    end
    key(b);
    req_q.push_back('{a: model[a], b: model[b], op: op});
    alu_model(model[a], model[b], op, r, e);
    wait_req(ok);
    if (!ok) return;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (start_in_exec) begin
      start   = 1'b1;
      set_num = 16'h9999;
      @(negedge clk);
      start = 1'b0;
    end
    alu_ack    = 1'b1;
    alu_err    = e;
    alu_result = e ? W'($urandom_range(0, 255)) : W'(r);
    @(negedge clk);
    alu_ack = 1'b0;
    alu_err = 1'b0;
    if (!e) begin
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      model[lo] = r;
      model.delete(hi);
    end
    check_state("move", e ? 1 : 0);
    @(negedge clk);
    chk("move_err_clear", move_err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b, tries;
    bit ok;
    rst = 1'b1; start = 1'b0; set_num = '0; key_valid = 1'b0; key_code = '0;
    alu_ack = 1'b0; alu_err = 1'b0; alu_result = '0;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    model = '{0, 0, 0, 0};
    check_state("reset", 0);
    chk("reset_alu_req", alu_req, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_alu_op", alu_op, 0);

    // Basic load and 1+2
    load(1, 2, 3, 4, 0);
    move(0, 0, 1, 0, 0);

    // Ignored keys: B==A, op in SEL_B, out-of-range slot in SEL_A
    load(1, 2, 3, 4, 0);
    move(2, 2, 3, 1, 0);
    move(0, 0, 1, 1, 1);

    // 3/2 rejected, then a legal move from SEL_A
    load(1, 2, 3, 4, 0);
    move(2, 3, 1, 0, 0);
    move(0, 0, 1, 0, 0);

    // Winning and losing games, reload from DONE
    load(1, 2, 3, 4, 0);
    move(0, 2, 1, 0, 0);
    move(0, 2, 1, 0, 0);
    move(0, 2, 1, 0, 0);
    load(1, 2, 3, 4, 0);
    move(2, 2, 3, 0, 0);
    move(2, 2, 1, 0, 0);
    move(1, 1, 0, 0, 0);
    load(1, 2, 3, 4, 0);

    // Restart from SEL_B with a key in the same cycle
    key(0);
    key(4);
    load(5, 6, 7, 8, 1);
    move(0, 0, 1, 0, 0);

`ifdef MOVE_SEQUENCER_UNDO_EN
    load(1, 2, 3, 4, 0);
    move(0, 0, 1, 0, 0);
    key(9);
    model = '{1, 2, 3, 4};
    check_state("undo", 0);
    key(9);
    check_state("undo_again", 0);
`endif

    // Reset while a request is outstanding
    load(1, 2, 3, 4, 0);
    key(0);
    key(4);
    key(1);
    req_q.push_back('{a: 1, b: 2, op: 0});
    wait_req(ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_exec_req", alu_req, 0);
    model = '{0, 0, 0, 0};
    check_state("rst_exec", 0);
    alu_ack    = 1'b1;
    alu_result = 8'd77;
    @(negedge clk);
    alu_ack = 1'b0;
    check_state("late_ack", 0);
    key(0);
    key(4);
    key(1);
    repeat (4) @(negedge clk);
    chk("idle_no_req", alu_req, 0);

    // Random games
    for (int g = 0; g < 10; g++) begin
      load($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 1));
      tries = 0;
      while (model.size() > 1 && tries < 10) begin
        a = $urandom_range(0, model.size() - 1);
        b = (a + 1 + $urandom_range(0, model.size() - 2)) % model.size();
        move(a, $urandom_range(0, 3), b, $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
        tries++;
      end
    end

    repeat (2) @(negedge clk);
    chk("req_q_drained", req_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
